// File: rtl/mmu_xlat_router.sv
// mmu_xlat_router
//   MIPS MMU front-end for NUM_CH requester channels. Each channel's virtual
//   address is translated with the fixed kseg0/kseg1 segment map. Cached
//   requests go straight through to that channel's own cache port with no added
//   latency. Uncached requests from all channels share one uncached port,
//   round-robin arbitrated through a registered IDLE/BUSY/RESP FSM.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   k0_uncached           1 = kseg0 accesses are uncached
//   req_valid_i/addr/be/wdata   per-channel request (be all zero = read)
//   req_ready_o/rdata_o   per-channel completion pulse and read data
//   cache_*               per-channel cache port (combinational pass-through)
//   unc_*                 shared uncached port; unc_owner_o = granted channel
module mmu_xlat_router #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned BE_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     k0_uncached,
    input  logic [NUM_CH-1:0]        req_valid_i,
    input  logic [NUM_CH*32-1:0]     req_addr_i,
    input  logic [NUM_CH*BE_W-1:0]   req_be_i,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    output logic [NUM_CH*DATA_W-1:0] req_rdata_o,
    output logic [NUM_CH-1:0]        cache_en_o,
    output logic [NUM_CH*32-1:0]     cache_addr_o,
    output logic [NUM_CH*BE_W-1:0]   cache_be_o,
    output logic [NUM_CH*DATA_W-1:0] cache_wdata_o,
    input  logic [NUM_CH-1:0]        cache_ready_i,
    input  logic [NUM_CH*DATA_W-1:0] cache_rdata_i,
    output logic                     unc_en_o,
    output logic [31:0]              unc_addr_o,
    output logic [BE_W-1:0]          unc_be_o,
    output logic [DATA_W-1:0]        unc_wdata_o,
    input  logic                     unc_ready_i,
    input  logic [DATA_W-1:0]        unc_rdata_i,
    output logic [CH_W-1:0]          unc_owner_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q;
    logic [CH_W-1:0]   owner_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [DATA_W-1:0] resp_data_q;

    logic [NUM_CH-1:0] cached;
    logic [NUM_CH-1:0] cand;
    logic [31:0]       paddr_a [NUM_CH];
    logic [BE_W-1:0]   be_a    [NUM_CH];
    logic [DATA_W-1:0] wdata_a [NUM_CH];

    logic              grant_any;
    logic [CH_W-1:0]   grant_idx;

    // Per-channel translation, cache pass-through and response merge
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [31:0] vaddr;
        logic [2:0]  seg;
        logic        unmapped;
        logic        resp_hit;

        assign vaddr    = req_addr_i[32*g +: 32];
        assign seg      = vaddr[31:29];
        assign unmapped = (seg == 3'b100) || (seg == 3'b101);

        // kseg1 is always uncached; kseg0 follows k0_uncached; all else cached
        assign cached[g] = (seg == 3'b101) ? 1'b0 :
                           (seg == 3'b100) ? ~k0_uncached : 1'b1;

        assign paddr_a[g] = unmapped ? {3'b000, vaddr[28:0]} : vaddr;
        assign be_a[g]    = req_be_i[BE_W*g +: BE_W];
        assign wdata_a[g] = req_wdata_i[DATA_W*g +: DATA_W];

        assign cache_en_o[g]                      = req_valid_i[g] & cached[g] & ~rst;
        assign cache_addr_o[32*g +: 32]           = paddr_a[g];
        assign cache_be_o[BE_W*g +: BE_W]         = be_a[g];
        assign cache_wdata_o[DATA_W*g +: DATA_W]  = wdata_a[g];

        assign resp_hit = (state_q == StResp) && (owner_q == CH_W'(g));

        assign req_ready_o[g] = (cached[g] & req_valid_i[g] & cache_ready_i[g]) | resp_hit;
        assign req_rdata_o[DATA_W*g +: DATA_W] =
            resp_hit ? resp_data_q : cache_rdata_i[DATA_W*g +: DATA_W];
    end

    assign cand = req_valid_i & ~cached;

    // Round-robin pick: first candidate after the last served channel
    always_comb begin
        logic [CH_W-1:0] cur;
        grant_any = 1'b0;
        grant_idx = '0;
        cur       = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cur == CH_W'(NUM_CH - 1)) begin
                cur = '0;
            end else begin
                cur = cur + CH_W'(1);
            end
            if (!grant_any && cand[cur]) begin
                grant_any = 1'b1;
                grant_idx = cur;
            end
        end
    end

    // Uncached request/response FSM; the payload is captured at grant so later
    // address or k0_uncached changes cannot disturb an in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            unc_en_o    <= 1'b0;
            unc_addr_o  <= '0;
            unc_be_o    <= '0;
            unc_wdata_o <= '0;
            resp_data_q <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        unc_addr_o  <= paddr_a[grant_idx];
                        unc_be_o    <= be_a[grant_idx];
                        unc_wdata_o <= wdata_a[grant_idx];
                        owner_q     <= grant_idx;
                        unc_en_o    <= 1'b1;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (unc_ready_i) begin
                        resp_data_q <= unc_rdata_i;
                        unc_en_o    <= 1'b0;
                        rr_ptr_q    <= owner_q;
                        state_q     <= StResp;
                    end
                end
                // Single-cycle response slot; no arbitration so a held valid
                // is not reissued.
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    unc_en_o <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign unc_owner_o = owner_q;

endmodule

// File: tb/tb_mmu_xlat_router.sv
module tb_mmu_xlat_router;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int CH_W   = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     k0_uncached;
    logic [NUM_CH-1:0]        req_valid_i;
    logic [NUM_CH*32-1:0]     req_addr_i;
    logic [NUM_CH*BE_W-1:0]   req_be_i;
    logic [NUM_CH*DATA_W-1:0] req_wdata_i;
    logic [NUM_CH-1:0]        req_ready_o;
    logic [NUM_CH*DATA_W-1:0] req_rdata_o;
    logic [NUM_CH-1:0]        cache_en_o;
    logic [NUM_CH*32-1:0]     cache_addr_o;
    logic [NUM_CH*BE_W-1:0]   cache_be_o;
    logic [NUM_CH*DATA_W-1:0] cache_wdata_o;
    logic [NUM_CH-1:0]        cache_ready_i;
    logic [NUM_CH*DATA_W-1:0] cache_rdata_i;
    logic                     unc_en_o;
    logic [31:0]              unc_addr_o;
    logic [BE_W-1:0]          unc_be_o;
    logic [DATA_W-1:0]        unc_wdata_o;
    logic                     unc_ready_i;
    logic [DATA_W-1:0]        unc_rdata_i;
    logic [CH_W-1:0]          unc_owner_o;

    int n_cmp = 0;
    int n_err = 0;

    mmu_xlat_router #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .k0_uncached(k0_uncached),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_be_i(req_be_i),
        .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o),
        .cache_en_o(cache_en_o), .cache_addr_o(cache_addr_o), .cache_be_o(cache_be_o),
        .cache_wdata_o(cache_wdata_o), .cache_ready_i(cache_ready_i),
        .cache_rdata_i(cache_rdata_i), .unc_en_o(unc_en_o), .unc_addr_o(unc_addr_o),
        .unc_be_o(unc_be_o), .unc_wdata_o(unc_wdata_o), .unc_ready_i(unc_ready_i),
        .unc_rdata_i(unc_rdata_i), .unc_owner_o(unc_owner_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference translation written from the segment address ranges
    function automatic logic [31:0] ref_paddr(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
        if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
        return a;
    endfunction

    function automatic bit ref_cached(input logic [31:0] a, input logic k0u);
        if (a >= 32'hA000_0000 && a < 32'hC000_0000) return 1'b0;
        if (a >= 32'h8000_0000 && a < 32'hA000_0000) return !k0u;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        req_valid_i   = '0;
        req_addr_i    = '0;
        req_be_i      = '0;
        req_wdata_i   = '0;
        cache_ready_i = '0;
        cache_rdata_i = '0;
        unc_ready_i   = 1'b0;
        unc_rdata_i   = '0;
    endtask

    task automatic set_req(input int ch, input logic v, input logic [31:0] a,
                           input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
        req_valid_i[ch]                  = v;
        req_addr_i[32*ch +: 32]          = a;
        req_be_i[BE_W*ch +: BE_W]        = be;
        req_wdata_i[DATA_W*ch +: DATA_W] = wd;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        k0_uncached = 1'b0;
        rst = 1'b1;
        set_req(0, 1'b1, 32'h0000_0100, '0, '0);
        set_req(1, 1'b1, 32'hA000_0200, '0, '0);
        tick();
        tick();
        #1;
        n_cmp++; if (cache_en_o !== 2'b00) begin n_err++; $display("FAIL rst_cache_en: got %b, want 00", cache_en_o); end
        n_cmp++; if (unc_en_o !== 1'b0) begin n_err++; $display("FAIL rst_unc_en: got %b, want 0", unc_en_o); end
        n_cmp++; if (unc_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_unc_addr: got %h, want 0", unc_addr_o); end
        n_cmp++; if ({unc_be_o, unc_wdata_o} !== '0) begin n_err++; $display("FAIL rst_unc_payload: got %h/%h, want 0", unc_be_o, unc_wdata_o); end
        n_cmp++; if (unc_owner_o !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %h, want 0", unc_owner_o); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b, want 00", req_ready_o); end
        do_reset();
    endtask

    task automatic test_cached_read;
        k0_uncached = 1'b0;
        set_req(0, 1'b1, 32'h8000_1000, 4'b0000, '0);
        cache_ready_i = 2'b01;
        cache_rdata_i[31:0] = 32'h1234_5678;
        #1;
        n_cmp++; if (cache_en_o[0] !== 1'b1) begin n_err++; $display("FAIL cr_en: got %b, want 1", cache_en_o[0]); end
        n_cmp++; if (cache_addr_o[31:0] !== 32'h0000_1000) begin n_err++; $display("FAIL cr_addr: got %h, want 00001000", cache_addr_o[31:0]); end
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL cr_ready: got %b, want 01", req_ready_o); end
        n_cmp++; if (req_rdata_o[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL cr_rdata: got %h, want 12345678", req_rdata_o[31:0]); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (unc_en_o !== 1'b0) begin n_err++; $display("FAIL cr_unc_en: got %b, want 0", unc_en_o); end
    endtask

    task automatic test_uncached_write;
        set_req(1, 1'b1, 32'hBFC0_0010, 4'b0011, 32'hAABB_CCDD);
        #1;
        n_cmp++; if (cache_en_o !== 2'b00) begin n_err++; $display("FAIL uw_cache_en: got %b, want 00", cache_en_o); end
        tick();
        #1;
        n_cmp++; if (unc_en_o !== 1'b1) begin n_err++; $display("FAIL uw_en: got %b, want 1", unc_en_o); end
        n_cmp++; if (unc_addr_o !== 32'h1FC0_0010) begin n_err++; $display("FAIL uw_addr: got %h, want 1fc00010", unc_addr_o); end
        n_cmp++; if (unc_be_o !== 4'b0011) begin n_err++; $display("FAIL uw_be: got %b, want 0011", unc_be_o); end
        n_cmp++; if (unc_wdata_o !== 32'hAABB_CCDD) begin n_err++; $display("FAIL uw_wdata: got %h, want aabbccdd", unc_wdata_o); end
        n_cmp++; if (unc_owner_o !== 1'b1) begin n_err++; $display("FAIL uw_owner: got %h, want 1", unc_owner_o); end
        tick();
        #1;
        n_cmp++; if ({unc_en_o, req_ready_o} !== 3'b100) begin n_err++; $display("FAIL uw_busy2: got %b, want 100", {unc_en_o, req_ready_o}); end
        unc_ready_i = 1'b1;
        unc_rdata_i = 32'hCAFE_F00D;
        tick();
        unc_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL uw_resp: got %b, want 10", req_ready_o); end
        n_cmp++; if (req_rdata_o[63:32] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL uw_rdata: got %h, want cafef00d", req_rdata_o[63:32]); end
        n_cmp++; if (unc_en_o !== 1'b0) begin n_err++; $display("FAIL uw_resp_en: got %b, want 0", unc_en_o); end
        clear_inputs();
        tick();
        #1;
        n_cmp++; if ({unc_en_o, req_ready_o} !== 3'b000) begin n_err++; $display("FAIL uw_after: got %b, want 000", {unc_en_o, req_ready_o}); end
    endtask

    task automatic test_round_robin;
        int grants[NUM_CH];
        int pulses[NUM_CH];
        int exp_owner;
        int total;
        logic prev_en;
        do_reset();
        set_req(0, 1'b1, 32'hA000_0100, '0, '0);
        set_req(1, 1'b1, 32'hA000_0200, '0, '0);
        exp_owner = 0;
        total = 0;
        prev_en = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin grants[c] = 0; pulses[c] = 0; end
        for (int i = 0; i < 12; i++) begin
            #1;
            if (unc_en_o && !prev_en) begin
                n_cmp++; if (unc_owner_o !== exp_owner[CH_W-1:0]) begin n_err++; $display("FAIL rr_owner: got %0d, want %0d", unc_owner_o, exp_owner); end
                n_cmp++; if (unc_addr_o !== ref_paddr(req_addr_i[32*exp_owner +: 32])) begin n_err++; $display("FAIL rr_addr: got %h, want %h", unc_addr_o, ref_paddr(req_addr_i[32*exp_owner +: 32])); end
                grants[unc_owner_o]++;
                total++;
                exp_owner = (exp_owner + 1) % NUM_CH;
            end
            for (int c = 0; c < NUM_CH; c++) if (req_ready_o[c]) pulses[c]++;
            prev_en = unc_en_o;
            unc_ready_i = unc_en_o;
            tick();
        end
        n_cmp++; if (total !== 4) begin n_err++; $display("FAIL rr_grants: got %0d, want 4", total); end
        for (int c = 0; c < NUM_CH; c++) begin
            n_cmp++; if (pulses[c] !== 2) begin n_err++; $display("FAIL rr_pulses: ch%0d got %0d, want 2", c, pulses[c]); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_k0_mix;
        k0_uncached = 1'b1;
        set_req(0, 1'b1, 32'h8000_0040, 4'b0000, '0);
        set_req(1, 1'b1, 32'h0040_0000, 4'b0000, '0);
        cache_ready_i = 2'b10;
        cache_rdata_i[63:32] = 32'h0BAD_BEEF;
        #1;
        n_cmp++; if (cache_en_o !== 2'b10) begin n_err++; $display("FAIL k0_cache_en: got %b, want 10", cache_en_o); end
        n_cmp++; if (cache_addr_o[63:32] !== 32'h0040_0000) begin n_err++; $display("FAIL k0_cache_addr: got %h, want 00400000", cache_addr_o[63:32]); end
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL k0_ready: got %b, want 10", req_ready_o); end
        n_cmp++; if (req_rdata_o[63:32] !== 32'h0BAD_BEEF) begin n_err++; $display("FAIL k0_rdata1: got %h, want 0badbeef", req_rdata_o[63:32]); end
        tick();
        set_req(1, 1'b0, '0, '0, '0);
        cache_ready_i = 2'b00;
        // Post-grant changes must not leak into the captured transaction
        k0_uncached = 1'b0;
        set_req(0, 1'b1, 32'hA000_0080, 4'b0000, '0);
        #1;
        n_cmp++; if ({unc_en_o, unc_owner_o} !== 2'b10) begin n_err++; $display("FAIL k0_grant: got %b, want 10", {unc_en_o, unc_owner_o}); end
        n_cmp++; if (unc_addr_o !== 32'h0000_0040) begin n_err++; $display("FAIL k0_unc_addr: got %h, want 00000040", unc_addr_o); end
        tick();
        #1;
        n_cmp++; if (unc_addr_o !== 32'h0000_0040) begin n_err++; $display("FAIL k0_hold_addr: got %h, want 00000040", unc_addr_o); end
        unc_ready_i = 1'b1;
        unc_rdata_i = 32'h55AA_55AA;
        tick();
        unc_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL k0_resp: got %b, want 01", req_ready_o); end
        n_cmp++; if (req_rdata_o[31:0] !== 32'h55AA_55AA) begin n_err++; $display("FAIL k0_rdata0: got %h, want 55aa55aa", req_rdata_o[31:0]); end
        clear_inputs();
        tick();
        #1;
        n_cmp++; if (unc_en_o !== 1'b0) begin n_err++; $display("FAIL k0_idle: got %b, want 0", unc_en_o); end
    endtask

    task automatic test_reset_mid_busy;
        do_reset();
        set_req(0, 1'b1, 32'hA000_0010, '0, '0);
        tick();
        #1;
        n_cmp++; if (unc_en_o !== 1'b1) begin n_err++; $display("FAIL rb_busy: got %b, want 1", unc_en_o); end
        rst = 1'b1;
        unc_ready_i = 1'b1;
        tick();
        #1;
        n_cmp++; if ({unc_en_o, req_ready_o} !== 3'b000) begin n_err++; $display("FAIL rb_abandon: got %b, want 000", {unc_en_o, req_ready_o}); end
        rst = 1'b0;
        clear_inputs();
        set_req(1, 1'b1, 32'hA000_0020, '0, '0);
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL rb_nopulse: got %b, want 00", req_ready_o); end
        tick();
        #1;
        n_cmp++; if ({unc_en_o, unc_owner_o} !== 2'b11) begin n_err++; $display("FAIL rb_regrant: got %b, want 11", {unc_en_o, unc_owner_o}); end
        n_cmp++; if (unc_addr_o !== 32'h0000_0020) begin n_err++; $display("FAIL rb_addr: got %h, want 00000020", unc_addr_o); end
        unc_ready_i = 1'b1;
        tick();
        unc_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL rb_resp: got %b, want 10", req_ready_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_drop_valid;
        set_req(0, 1'b1, 32'hA000_0030, '0, '0);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        tick();
        #1;
        n_cmp++; if ({unc_en_o, unc_owner_o} !== 2'b10) begin n_err++; $display("FAIL dv_busy: got %b, want 10", {unc_en_o, unc_owner_o}); end
        n_cmp++; if (unc_addr_o !== 32'h0000_0030) begin n_err++; $display("FAIL dv_addr: got %h, want 00000030", unc_addr_o); end
        unc_ready_i = 1'b1;
        unc_rdata_i = 32'h1357_9BDF;
        tick();
        unc_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL dv_resp: got %b, want 01", req_ready_o); end
        n_cmp++; if (req_rdata_o[31:0] !== 32'h1357_9BDF) begin n_err++; $display("FAIL dv_rdata: got %h, want 13579bdf", req_rdata_o[31:0]); end
        tick();
        #1;
        n_cmp++; if ({unc_en_o, req_ready_o} !== 3'b000) begin n_err++; $display("FAIL dv_idle: got %b, want 000", {unc_en_o, req_ready_o}); end
        tick();
        #1;
        n_cmp++; if (unc_en_o !== 1'b0) begin n_err++; $display("FAIL dv_noreissue: got %b, want 0", unc_en_o); end
    endtask

    // Randomized traffic against a transaction-level model of the port
    task automatic test_random(input logic k0u, input int cycles);
        bit              pend [NUM_CH];
        logic [31:0]     p_addr [NUM_CH];
        logic [BE_W-1:0] p_be [NUM_CH];
        logic [31:0]     p_wd [NUM_CH];
        int              phase;     // 0 port free, 1 access outstanding, 2 response slot
        int              m_owner, m_last;
        logic [31:0]     m_addr, m_wd, m_rdata;
        logic [BE_W-1:0] m_be;
        bit              exp_rdy, done;
        k0_uncached = k0u;
        do_reset();
        phase = 0; m_owner = 0; m_last = NUM_CH - 1;
        m_addr = '0; m_wd = '0; m_be = '0; m_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c] = 1'b0; p_addr[c] = '0; p_be[c] = '0; p_wd[c] = '0;
        end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pend[c] && $urandom_range(1, 0) == 1) begin
                    case ($urandom_range(2, 0))
                        0:       p_addr[c] = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFC);
                        1:       p_addr[c] = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFC);
                        default: p_addr[c] = $urandom & 32'h7FFF_FFFC;
                    endcase
                    p_be[c] = ($urandom_range(3, 0) == 0) ? '0 : BE_W'($urandom);
                    p_wd[c] = $urandom;
                    pend[c] = 1'b1;
                end
                set_req(c, pend[c], p_addr[c], p_be[c], p_wd[c]);
                cache_ready_i[c] = $urandom_range(1, 0) == 1;
                cache_rdata_i[DATA_W*c +: DATA_W] = $urandom;
            end
            unc_ready_i = $urandom_range(2, 0) == 0;
            unc_rdata_i = $urandom;
            #1;
            n_cmp++; if (unc_en_o !== (phase == 1)) begin n_err++; $display("FAIL rnd_unc_en: cyc %0d got %b, want %b", cyc, unc_en_o, phase == 1); end
            if (phase == 1) begin
                n_cmp++; if ({unc_addr_o, unc_be_o, unc_wdata_o, unc_owner_o} !== {m_addr, m_be, m_wd, m_owner[CH_W-1:0]}) begin
                    n_err++; $display("FAIL rnd_unc_payload: cyc %0d got %h/%h/%h/%0d, want %h/%h/%h/%0d", cyc, unc_addr_o, unc_be_o, unc_wdata_o, unc_owner_o, m_addr, m_be, m_wd, m_owner);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                bit cch;
                cch = ref_cached(p_addr[c], k0u);
                exp_rdy = (pend[c] && cch && cache_ready_i[c]) || (phase == 2 && m_owner == c);
                n_cmp++; if (req_ready_o[c] !== exp_rdy) begin n_err++; $display("FAIL rnd_ready: cyc %0d ch%0d got %b, want %b", cyc, c, req_ready_o[c], exp_rdy); end
                if (phase == 2 && m_owner == c) begin
                    n_cmp++; if (req_rdata_o[DATA_W*c +: DATA_W] !== m_rdata) begin n_err++; $display("FAIL rnd_unc_rdata: cyc %0d ch%0d got %h, want %h", cyc, c, req_rdata_o[DATA_W*c +: DATA_W], m_rdata); end
                end else if (exp_rdy) begin
                    n_cmp++; if (req_rdata_o[DATA_W*c +: DATA_W] !== cache_rdata_i[DATA_W*c +: DATA_W]) begin n_err++; $display("FAIL rnd_cache_rdata: cyc %0d ch%0d got %h, want %h", cyc, c, req_rdata_o[DATA_W*c +: DATA_W], cache_rdata_i[DATA_W*c +: DATA_W]); end
                end
                n_cmp++; if (cache_en_o[c] !== (pend[c] && cch)) begin n_err++; $display("FAIL rnd_cache_en: cyc %0d ch%0d got %b, want %b", cyc, c, cache_en_o[c], pend[c] && cch); end
                if (pend[c] && cch) begin
                    n_cmp++; if (cache_addr_o[32*c +: 32] !== ref_paddr(p_addr[c])) begin n_err++; $display("FAIL rnd_cache_addr: cyc %0d ch%0d got %h, want %h", cyc, c, cache_addr_o[32*c +: 32], ref_paddr(p_addr[c])); end
                end
            end
            // Advance the model across the clock edge
            if (phase == 0) begin
                done = 1'b0;
                for (int k = 1; k <= NUM_CH; k++) begin
                    int c;
                    c = (m_last + k) % NUM_CH;
                    if (!done && pend[c] && !ref_cached(p_addr[c], k0u)) begin
                        done = 1'b1; m_owner = c;
                        m_addr = ref_paddr(p_addr[c]); m_be = p_be[c]; m_wd = p_wd[c];
                    end
                end
                if (done) phase = 1;
            end else if (phase == 1) begin
                if (unc_ready_i) begin
                    m_rdata = unc_rdata_i; m_last = m_owner; phase = 2;
                end
            end else begin
                pend[m_owner] = 1'b0;
                phase = 0;
            end
            for (int c = 0; c < NUM_CH; c++)
                if (pend[c] && ref_cached(p_addr[c], k0u) && cache_ready_i[c]) pend[c] = 1'b0;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        k0_uncached = 1'b0;
        test_reset();
        test_cached_read();
        test_uncached_write();
        test_round_robin();
        test_k0_mix();
        test_reset_mid_busy();
        test_drop_valid();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
